// File: rtl/pcm_frame_sync_if.sv
// Bit-stream, configuration and status bundle between the bitsync channel
// and one pcm_frame_sync instance.
interface pcm_frame_sync_if #(
  parameter int PATTERN_BITS = 32,
  parameter int LEN_WIDTH    = 16
);
  logic                    symEn;
  logic                    bitIn;
  logic                    bitsyncLock;
  logic [PATTERN_BITS-1:0] syncPattern;
  logic [PATTERN_BITS-1:0] syncMask;
  logic [LEN_WIDTH-1:0]    frameLength;
  logic [5:0]              searchTol;
  logic [5:0]              lockTol;
  logic [3:0]              verifyCount;
  logic [3:0]              flywheelCount;
  logic                    bitOut;
  logic                    bitEn;
  logic                    frameStart;
  logic [LEN_WIDTH-1:0]    bitCount;
  logic                    frameLock;
  logic [1:0]              frameState;
  logic                    inverted;

  modport master (
    output symEn, bitIn, bitsyncLock, syncPattern, syncMask, frameLength,
           searchTol, lockTol, verifyCount, flywheelCount,
    input  bitOut, bitEn, frameStart, bitCount, frameLock, frameState, inverted
  );

  modport slave (
    input  symEn, bitIn, bitsyncLock, syncPattern, syncMask, frameLength,
           searchTol, lockTol, verifyCount, flywheelCount,
    output bitOut, bitEn, frameStart, bitCount, frameLock, frameState, inverted
  );
endinterface

// File: rtl/pcm_frame_sync.sv
// PCM frame synchronizer: masked sync-word correlator plus SEARCH/VERIFY/LOCK/FLYWHEEL.
// Optional FRAME_SYNC_INVERT_EN adds complemented-pattern acquisition and bit correction.
module pcm_frame_sync #(
  parameter int PATTERN_BITS = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic            clk,
  input  logic            reset,
  pcm_frame_sync_if.slave bus
);
  localparam int STAGES = 1;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(PATTERN_BITS);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCK = 2'd2, FLYWHEEL = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [STAGES:0]         vld_pipe_q;
  logic [PATTERN_BITS-1:0] sr_q;
  logic                    b1_q;
  logic                    bit_out_q;
  logic                    frame_start_q, fs_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [3:0]              good_q, good_d;
  logic [3:0]              bad_q, bad_d;
  logic                    inv_q, inv_d;
  logic [4:0]              good_inc, bad_inc;
  logic [15:0]             errs_true, errs_sel, stol, ltol;
  logic                    cfg_ok, at_check, pass, go;

  function automatic logic [15:0] popcnt(input logic [PATTERN_BITS-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < PATTERN_BITS; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  assign errs_true = popcnt((sr_q ^ bus.syncPattern) & bus.syncMask);
  assign stol      = {10'd0, bus.searchTol};
  assign ltol      = {10'd0, bus.lockTol};
  assign cfg_ok    = bus.frameLength >= MIN_LEN;
  assign cnt_inc   = (cnt_q >= bus.frameLength) ? LEN_WIDTH'(1) : cnt_q + LEN_WIDTH'(1);
  assign at_check  = (cnt_inc == bus.frameLength);
  assign good_inc  = {1'b0, good_q} + 5'd1;
  assign bad_inc   = {1'b0, bad_q} + 5'd1;

`ifdef FRAME_SYNC_INVERT_EN
  logic [15:0] errs_inv;
  assign errs_inv = popcnt((~sr_q ^ bus.syncPattern) & bus.syncMask);
  // once acquired, checks stick to the polarity found in SEARCH
  assign errs_sel = inv_q ? errs_inv : errs_true;
`else
  assign errs_sel = errs_true;
`endif
  assign pass = (errs_sel <= ltol);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    bad_d   = bad_q;
    inv_d   = inv_q;
    fs_d    = 1'b0;
    go      = 1'b0;
    if (!bus.bitsyncLock || !cfg_ok) begin
      state_d = SEARCH;
      cnt_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      inv_d   = 1'b0;
    end else if (vld_pipe_q[0]) begin
      // frame timing free-runs in every state except SEARCH
      if (state_q != SEARCH) begin
        cnt_d = cnt_inc;
        fs_d  = (cnt_inc == LEN_WIDTH'(1));
      end
      unique case (state_q)
        SEARCH: begin
          cnt_d = '0;
          if (errs_true <= stol) begin
            go    = 1'b1;
            inv_d = 1'b0;
          end
`ifdef FRAME_SYNC_INVERT_EN
          else if (errs_inv <= stol) begin
            go    = 1'b1;
            inv_d = 1'b1;
          end
`endif
          if (go) begin
            good_d  = 4'd1;
            bad_d   = '0;
            state_d = (bus.verifyCount <= 4'd1) ? LOCK : VERIFY;
          end
        end
        VERIFY: if (at_check) begin
          if (pass) begin
            good_d = good_inc[3:0];
            if (good_inc >= {1'b0, bus.verifyCount}) state_d = LOCK;
          end else begin
            state_d = SEARCH;
            good_d  = '0;
            inv_d   = 1'b0;
          end
        end
        LOCK: if (at_check && !pass) begin
          bad_d = 4'd1;
          if (bus.flywheelCount == 4'd0) begin
            state_d = SEARCH;
            good_d  = '0;
            bad_d   = '0;
            inv_d   = 1'b0;
          end else begin
            state_d = FLYWHEEL;
          end
        end
        FLYWHEEL: if (at_check) begin
          if (pass) begin
            state_d = LOCK;
            bad_d   = '0;
          end else if (bad_inc > {1'b0, bus.flywheelCount}) begin
            state_d = SEARCH;
            good_d  = '0;
            bad_d   = '0;
            inv_d   = 1'b0;
          end else begin
            bad_d = bad_inc[3:0];
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q    <= '0;
      sr_q          <= '0;
      b1_q          <= 1'b0;
      bit_out_q     <= 1'b0;
      frame_start_q <= 1'b0;
      cnt_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      inv_q         <= 1'b0;
      state_q       <= SEARCH;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], bus.symEn};
      if (bus.symEn) begin
        sr_q <= {sr_q[PATTERN_BITS-2:0], bus.bitIn};
        b1_q <= bus.bitIn;
      end
      if (vld_pipe_q[0]) bit_out_q <= b1_q ^ inv_d;
      frame_start_q <= fs_d;
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      inv_q         <= inv_d;
      state_q       <= state_d;
    end
  end

  assign bus.bitEn      = vld_pipe_q[STAGES];
  assign bus.bitOut     = bit_out_q;
  assign bus.frameStart = frame_start_q;
  assign bus.bitCount   = cnt_q;
  assign bus.frameLock  = state_q[1];
  assign bus.frameState = state_q;
  assign bus.inverted   = inv_q;
endmodule

// File: tb/tb_pcm_frame_sync.sv
// Directed bench for pcm_frame_sync: acquisition, flywheel, tolerances, lock loss,
// mid-frame reset with back-to-back symbols, and polarity handling.
module tb_pcm_frame_sync;
  localparam int PB = 32;
  localparam int LW = 16;
  localparam logic [31:0] PAT = 32'hFE6B2840;

  typedef struct {
    logic        bo;
    logic        fs;
    logic [15:0] bc;
    logic [1:0]  st;
    logic        lk;
    logic        inv;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcm_frame_sync_if #(.PATTERN_BITS(PB), .LEN_WIDTH(LW)) io();
  pcm_frame_sync #(.PATTERN_BITS(PB), .LEN_WIDTH(LW)) dut (.clk(clk), .reset(reset), .bus(io));

  int   checks = 0;
  int   errors = 0;
  bit   b2b = 1'b0;
  logic data [224];
  rec_t q[$];
  logic sent[$];

  always @(negedge clk) begin
    rec_t r;
    if (io.bitEn === 1'b1) begin
      r.bo = io.bitOut; r.fs = io.frameStart; r.bc = io.bitCount;
      r.st = io.frameState; r.lk = io.frameLock; r.inv = io.inverted;
      q.push_back(r);
    end
  end

  task automatic cap();
    q.delete();
    sent.delete();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    io.symEn = 1'b1; io.bitIn = b;
    sent.push_back(b);
    if (!b2b) begin
      @(negedge clk);
      io.symEn = 1'b0;
    end
  endtask

  task automatic flush();
    @(negedge clk);
    io.symEn = 1'b0; io.bitIn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic inv);
    for (int i = 0; i < 224; i++) send_bit(data[i] ^ inv);
    send_word(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (io.bitEn !== 1'b0) begin errors++; $display("FAIL rst_bitEn got %b want 0", io.bitEn); end
    checks++; if (io.bitOut !== 1'b0) begin errors++; $display("FAIL rst_bitOut got %b want 0", io.bitOut); end
    checks++; if (io.frameStart !== 1'b0) begin errors++; $display("FAIL rst_frameStart got %b want 0", io.frameStart); end
    checks++; if (io.bitCount !== 16'd0) begin errors++; $display("FAIL rst_bitCount got %0d want 0", io.bitCount); end
    checks++; if (io.frameLock !== 1'b0) begin errors++; $display("FAIL rst_frameLock got %b want 0", io.frameLock); end
    checks++; if (io.frameState !== 2'd0) begin errors++; $display("FAIL rst_frameState got %0d want 0", io.frameState); end
    checks++; if (io.inverted !== 1'b0) begin errors++; $display("FAIL rst_inverted got %b want 0", io.inverted); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    io.symEn = 1'b1; io.bitIn = 1'b1;
    @(negedge clk);
    io.symEn = 1'b0; io.bitIn = 1'b0;
    checks++; if (io.bitEn !== 1'b0) begin errors++; $display("FAIL lat_1clk bitEn got %b want 0", io.bitEn); end
    @(negedge clk);
    checks++; if (io.bitEn !== 1'b1) begin errors++; $display("FAIL lat_2clk bitEn got %b want 1", io.bitEn); end
    checks++; if (io.bitOut !== 1'b1) begin errors++; $display("FAIL lat_bitOut got %b want 1", io.bitOut); end
    @(negedge clk);
    checks++; if (io.bitEn !== 1'b0) begin errors++; $display("FAIL lat_pulse bitEn got %b want 0", io.bitEn); end
  endtask

  task automatic test_acquire();
    int nb;
    cap();
    send_word(PAT);
    flush();
    nb = 0;
    foreach (q[i]) if (q[i].fs) nb++;
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL acq_sync_size got %0d want 32", q.size()); end
    checks++; if (q[30].st !== 2'd0) begin errors++; $display("FAIL acq_pre_state got %0d want 0", q[30].st); end
    checks++; if (q[31].st !== 2'd1) begin errors++; $display("FAIL acq_verify got %0d want 1", q[31].st); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL acq_search_fs got %0d want 0", nb); end
    for (int f = 0; f < 2; f++) begin
      cap();
      send_frame(PAT, 1'b0);
      flush();
      nb = 0;
      foreach (q[i]) if (q[i].bc !== 16'(i + 1) || q[i].fs !== (i == 0)) nb++;
      checks++; if (q.size() !== 256) begin errors++; $display("FAIL acq_frame_size f%0d got %0d want 256", f, q.size()); end
      checks++; if (nb !== 0) begin errors++; $display("FAIL acq_count_fs f%0d got %0d bad want 0", f, nb); end
      checks++; if (q[254].st !== 2'd1) begin errors++; $display("FAIL acq_midstate f%0d got %0d want 1", f, q[254].st); end
      checks++; if (q[255].st !== (f == 0 ? 2'd1 : 2'd2)) begin errors++; $display("FAIL acq_state f%0d got %0d want %0d", f, q[255].st, (f == 0 ? 1 : 2)); end
      checks++; if (q[255].lk !== (f == 1)) begin errors++; $display("FAIL acq_lock f%0d got %b want %b", f, q[255].lk, (f == 1)); end
    end
  endtask

  task automatic test_flywheel();
    logic [31:0] words [6];
    logic [1:0]  exp_st [6];
    int nb;
    words = '{PAT ^ 32'h3, PAT ^ 32'h7, PAT, PAT ^ 32'h7, PAT ^ 32'h7, PAT ^ 32'h7};
    exp_st = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int f = 0; f < 6; f++) begin
      cap();
      send_frame(words[f], 1'b0);
      flush();
      nb = 0;
      foreach (q[i]) if (q[i].bc !== 16'(i + 1) || q[i].fs !== (i == 0)) nb++;
      checks++; if (nb !== 0) begin errors++; $display("FAIL fly_timing f%0d got %0d bad want 0", f, nb); end
      checks++; if (q[255].st !== exp_st[f]) begin errors++; $display("FAIL fly_state f%0d got %0d want %0d", f, q[255].st, exp_st[f]); end
      checks++; if (q[255].lk !== (exp_st[f] != 2'd0)) begin errors++; $display("FAIL fly_lock f%0d got %b want %b", f, q[255].lk, (exp_st[f] != 2'd0)); end
    end
  endtask

  task automatic test_search_tol();
    int nb;
    do_reset();
    io.frameLength = 16'd16;
    cap();
    send_word(PAT);
    flush();
    nb = 0;
    foreach (q[i]) if (q[i].st !== 2'd0) nb++;
    checks++; if (nb !== 0) begin errors++; $display("FAIL tol_short_len got %0d non-search want 0", nb); end
    io.frameLength = 16'd256;
    cap();
    for (int i = 0; i < 40; i++) send_bit(data[i]);
    send_word(PAT ^ 32'h0001_0000);
    flush();
    nb = 0;
    foreach (q[i]) if (q[i].st !== 2'd0 || q[i].fs !== 1'b0) nb++;
    checks++; if (nb !== 0) begin errors++; $display("FAIL tol0_stay got %0d bad want 0", nb); end
    io.searchTol = 6'd1;
    cap();
    for (int i = 0; i < 40; i++) send_bit(data[100 + i]);
    send_word(PAT ^ 32'h0001_0000);
    flush();
    checks++; if (q[70].st !== 2'd0) begin errors++; $display("FAIL tol1_pre got %0d want 0", q[70].st); end
    checks++; if (q[71].st !== 2'd1) begin errors++; $display("FAIL tol1_verify got %0d want 1", q[71].st); end
    io.searchTol = 6'd0;
  endtask

  task automatic test_lock_drop();
    do_reset();
    b2b = 1'b1;
    send_word(PAT);
    send_frame(PAT, 1'b0);
    send_frame(PAT, 1'b0);
    for (int i = 0; i < 100; i++) send_bit(data[i]);
    checks++; if (io.frameState !== 2'd2) begin errors++; $display("FAIL drop_pre_state got %0d want 2", io.frameState); end
    io.bitsyncLock = 1'b0;
    send_bit(data[100]);
    send_bit(data[101]);
    checks++; if (io.frameState !== 2'd0) begin errors++; $display("FAIL drop_state got %0d want 0", io.frameState); end
    checks++; if (io.frameLock !== 1'b0) begin errors++; $display("FAIL drop_lock got %b want 0", io.frameLock); end
    checks++; if (io.bitCount !== 16'd0) begin errors++; $display("FAIL drop_count got %0d want 0", io.bitCount); end
    checks++; if (io.bitEn !== 1'b1) begin errors++; $display("FAIL drop_bitEn got %b want 1", io.bitEn); end
    checks++; if (io.bitOut !== data[99]) begin errors++; $display("FAIL drop_bitOut got %b want %b", io.bitOut, data[99]); end
    flush();
    io.bitsyncLock = 1'b1;
    b2b = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nb;
    b2b = 1'b1;
    send_word(PAT);
    send_frame(PAT, 1'b0);
    send_frame(PAT, 1'b0);
    for (int i = 0; i < 50; i++) send_bit(data[i]);
    checks++; if (io.frameLock !== 1'b1) begin errors++; $display("FAIL b2b_pre_lock got %b want 1", io.frameLock); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({io.bitEn, io.bitOut, io.frameStart, io.frameLock, io.frameState, io.bitCount} !== '0)
      begin errors++; $display("FAIL b2b_async_rst got en%b out%b fs%b lk%b st%0d bc%0d want all 0",
        io.bitEn, io.bitOut, io.frameStart, io.frameLock, io.frameState, io.bitCount); end
    @(negedge clk);
    io.symEn = 1'b0;
    reset = 1'b0;
    cap();
    send_word(PAT);
    send_frame(PAT, 1'b0);
    send_frame(PAT, 1'b0);
    flush();
    nb = 0;
    foreach (q[i]) if (i < sent.size() && q[i].bo !== sent[i]) nb++;
    checks++; if (q.size() !== 544) begin errors++; $display("FAIL b2b_size got %0d want 544", q.size()); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL b2b_bits got %0d bad want 0", nb); end
    checks++; if (q[287].st !== 2'd1) begin errors++; $display("FAIL b2b_verify got %0d want 1", q[287].st); end
    checks++; if (q[542].st !== 2'd1) begin errors++; $display("FAIL b2b_prelock got %0d want 1", q[542].st); end
    checks++; if (q[543].st !== 2'd2) begin errors++; $display("FAIL b2b_relock got %0d want 2", q[543].st); end
    b2b = 1'b0;
  endtask

  task automatic test_inverted();
    int nb;
    do_reset();
    cap();
    send_word(~PAT);
    send_frame(~PAT, 1'b1);
    send_frame(~PAT, 1'b1);
    flush();
`ifdef FRAME_SYNC_INVERT_EN
    nb = 0;
    for (int i = 0; i < 224; i++) if (q[32 + i].bo !== data[i]) nb++;
    checks++; if (q[31].st !== 2'd1) begin errors++; $display("FAIL inv_verify got %0d want 1", q[31].st); end
    checks++; if (q[31].inv !== 1'b1) begin errors++; $display("FAIL inv_flag got %b want 1", q[31].inv); end
    checks++; if (q[31].bo !== PAT[0]) begin errors++; $display("FAIL inv_sync_bit got %b want %b", q[31].bo, PAT[0]); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL inv_data got %0d bad want 0", nb); end
    checks++; if (q[543].st !== 2'd2) begin errors++; $display("FAIL inv_lock got %0d want 2", q[543].st); end
`else
    nb = 0;
    foreach (q[i]) if (q[i].st !== 2'd0 || q[i].inv !== 1'b0 || (i < sent.size() && q[i].bo !== sent[i])) nb++;
    checks++; if (q.size() !== 544) begin errors++; $display("FAIL inv_size got %0d want 544", q.size()); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL inv_ignored got %0d bad want 0", nb); end
`endif
  endtask

  initial begin
    io.symEn = 1'b0; io.bitIn = 1'b0; io.bitsyncLock = 1'b1;
    io.syncPattern = PAT; io.syncMask = '1; io.frameLength = 16'd256;
    io.searchTol = 6'd0; io.lockTol = 6'd2; io.verifyCount = 4'd3; io.flywheelCount = 4'd2;
    for (int i = 0; i < 224; i++) data[i] = 1'($urandom_range(0, 1));
    test_reset();
    test_latency();
    test_acquire();
    test_flywheel();
    test_search_tol();
    test_lock_drop();
    test_back_to_back();
    test_inverted();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
